i2c_master: RTL

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master
// Description : Single-byte I2C master. Each transaction sends START, the
//               address byte {addr, rw} and one data byte (written or read),
//               checks the ACK bits, then sends STOP. SCL period = 4*DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_o,
  output logic       sda_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ADDR     = 3'd2,
    S_ADDR_ACK = 3'd3,
    S_DATA     = 3'd4,
    S_DATA_ACK = 3'd5,
    S_STOP     = 3'd6
  } state_t;

  localparam logic [7:0] C_DIV_LAST = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q;       // clocks within the current quarter
  logic [1:0] qtr_q;       // quarter within the current cell
  logic [2:0] bit_q;       // bit cell within ADDR / DATA
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rx_q;        // read shift register
  logic [7:0] rd_data_q;
  logic       ack_err_q;
  logic       done_q;

  logic       w_qtr_tick;  // last clock of a quarter
  logic       w_cell_end;  // last clock of a cell
  logic       w_sample;    // last clock of q2: SDA sample point
  logic       w_last_bit;
  logic [7:0] w_tx_byte;

  assign w_qtr_tick = (div_q == C_DIV_LAST);
  assign w_cell_end = w_qtr_tick && (qtr_q == 2'd3);
  assign w_sample   = w_qtr_tick && (qtr_q == 2'd2);
  assign w_last_bit = (bit_q == 3'd7);
  assign w_tx_byte  = {addr_q, rw_q};

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;

  // Next-state and bus drive, decoded from state and quarter position
  always_comb begin
    state_d = state_q;
    scl_o   = 1'b1;
    sda_oe  = 1'b0;
    sda_o   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        // SDA falls in the second half while SCL stays high
        if (qtr_q[1]) begin
          sda_oe = 1'b1;
          sda_o  = 1'b0;
        end
        if (w_cell_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        scl_o  = qtr_q[1];
        sda_oe = 1'b1;
        sda_o  = w_tx_byte[3'd7 - bit_q];
        if (w_cell_end && w_last_bit) state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_o = qtr_q[1];
        // ack_err_q was set at the q2 sample if the slave did not ACK
        if (w_cell_end) state_d = ack_err_q ? S_STOP : S_DATA;
      end
      S_DATA: begin
        scl_o = qtr_q[1];
        if (!rw_q) begin
          sda_oe = 1'b1;
          sda_o  = wdata_q[3'd7 - bit_q];
        end
        if (w_cell_end && w_last_bit) state_d = S_DATA_ACK;
      end
      S_DATA_ACK: begin
        // SDA released: slave ACK on write, master NACK on read
        scl_o = qtr_q[1];
        if (w_cell_end) state_d = S_STOP;
      end
      S_STOP: begin
        // SDA held low through q2, rises in q3 with SCL high
        scl_o = qtr_q[1];
        if (qtr_q != 2'd3) begin
          sda_oe = 1'b1;
          sda_o  = 1'b0;
        end
        if (w_cell_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timing counters, captured request, sampled bus data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_STOP) && w_cell_end;

      if (state_q == S_IDLE) begin
        div_q <= '0;
        qtr_q <= '0;
        bit_q <= '0;
        if (start) begin
          rw_q      <= rw;
          addr_q    <= addr;
          wdata_q   <= wr_data;
          ack_err_q <= 1'b0;
        end
      end else begin
        if (w_qtr_tick) begin
          div_q <= '0;
          qtr_q <= qtr_q + 2'd1;
          if (w_cell_end && (state_q == S_ADDR || state_q == S_DATA))
            bit_q <= bit_q + 3'd1;
        end else begin
          div_q <= div_q + 8'd1;
        end

        if (w_sample) begin
          case (state_q)
            S_ADDR_ACK: if (sda_i) ack_err_q <= 1'b1;
            S_DATA:     if (rw_q) rx_q <= {rx_q[6:0], sda_i};
            S_DATA_ACK: if (!rw_q && sda_i) ack_err_q <= 1'b1;
            default: ;
          endcase
        end

        if (state_q == S_DATA_ACK && w_cell_end && rw_q)
          rd_data_q <= rx_q;
      end
    end
  end

endmodule
`default_nettype wire
